axi_sram_ctrl: RTL and testbench
================================

# axi_sram_ctrl

AXI4 slave that converts AXI4 read/write bursts into single-bank synchronous SRAM accesses with a fixed read latency. It sits between the SoC interconnect's memory port and an inferred SRAM, serving CPU instruction fetches and data traffic from address 0x0. It handles one transaction at a time and returns OKAY on all responses.

## Interface

- AXI_ADDR_WIDTH, 32: AXI address width.
- AXI_DATA_WIDTH, 32: AXI data width; must equal SRAM_BANK_DATA_WIDTH.
- AXI_ID_WIDTH, 5: ID width.
- SRAM_BANK_ADDR_WIDTH, 32: bank word-address width.
- SRAM_BANK_DATA_WIDTH, 32: bank data width.
- SRAM_READ_LATENCY, 2: cycles from bank_cs (read) to valid bank_rdata; minimum 1.

Ports:

- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- aw_id/aw_addr/aw_len/aw_size/aw_burst  in  ID/ADDR/8/3/2  write address channel.
- aw_valid in 1, aw_ready out 1: write address handshake.
- w_data/w_strb/w_last  in  DATA/DATA÷8/1  write data channel.
- w_valid in 1, w_ready out 1: write data handshake.
- b_id/b_resp  out  ID/2  write response channel.
- b_valid out 1, b_ready in 1: write response handshake.
- ar_id/ar_addr/ar_len/ar_size/ar_burst  in  ID/ADDR/8/3/2  read address channel.
- ar_valid in 1, ar_ready out 1: read address handshake.
- r_id/r_data/r_resp/r_last  out  ID/DATA/2/1  read data channel.
- r_valid out 1, r_ready in 1: read data handshake.
- bank_addr  out  SRAM_BANK_ADDR_WIDTH  word address, equal to byte address >> log2(DATA/8).
- bank_cs  out  1  bank access strobe.
- bank_we  out  1  1 = write, 0 = read.
- bank_be  out  DATA/8  byte enables.
- bank_wdata  out  DATA  write data.
- bank_rdata  in  DATA  read data.

Lock, cache, prot, qos and user signals are not ported. User outputs are tied to 0 by the integrator.

## Operation

- FSM states: IDLE, WRITE, WRESP, RISSUE, RWAIT, RDATA.
- **IDLE**
  - aw_ready/ar_ready are asserted only in IDLE, for the selected channel.
  - If only one channel is valid, accept it.
  - If both are valid, round-robin: the channel not served last wins; writes win the first conflict after reset.
  - On accept, latch id, addr, len, size and burst, and clear the beat counter.
- **WRITE**
  - w_ready = 1.
  - Each W handshake drives, in the same cycle, bank_cs=1, bank_we=1, bank_be=w_strb, bank_wdata=w_data, bank_addr=current word address. The address then advances.
  - The beat with w_last=1, or beat number len+1, moves to WRESP. Extra beats are impossible because w_ready drops.
- **WRESP**: b_valid=1, b_id=latched id, b_resp=2'b00. Go to IDLE on b_ready.
- **RISSUE**: one cycle with bank_cs=1, bank_we=0, bank_be all ones, bank_addr=current word address. Go to RWAIT.
- **RWAIT**: wait SRAM_READ_LATENCY cycles. Capture bank_rdata into r_data at the end of the last wait cycle, then go to RDATA.
- **RDATA**
  - r_valid=1, r_id=latched id, r_resp=2'b00, r_last=(beat==len).
  - On r_ready: if last, go to IDLE; otherwise advance the address and go to RISSUE.
- **Address advance**
  - FIXED (00): constant.
  - INCR (01): aligned address + 2^size.
  - WRAP (10): increment, wrapping within a (len+1)·2^size-aligned window.
  - Burst type 11 is treated as INCR.
- Narrow reads return the full word; narrow writes rely on w_strb.
- All responses are OKAY; no error detection.

## Timing

- **Reset values**: all ready/valid outputs 0, bank_cs 0, bank_we 0, bank_be 0, bank_addr 0, bank_wdata 0, r_data 0, r_last 0, b_resp 0. FSM goes to IDLE and the round-robin pointer is set to prefer write.
- **Reset mid-burst**: the burst is abandoned and no response is issued.
- **Write timing**
  - AW handshake at cycle T: w_ready from T+1.
  - Back-to-back beats at 1 per cycle.
  - b_valid the cycle after the last W beat.
- **Read timing** (L = SRAM_READ_LATENCY)
  - AR handshake at T: bank_cs at T+1, first r_valid at T+2+L (T+4 for L=2).
  - Each subsequent beat: r_valid L+2 cycles after the previous r_ready handshake.
- r_data and r_valid are held stable until r_ready.
- b_valid is held until b_ready.
- bank_cs is 0 outside WRITE handshakes and RISSUE.

## Test plan

- **Single write then read**
  - Write 0xDEADBEEF at 0x10, strb 0xF, id 3 → bank_cs/we with bank_addr 4; b_valid with b_id 3, OKAY.
  - Read 0x10 → r_data 0xDEADBEEF, r_last 1, r_valid 4 cycles after AR handshake.
- **INCR write, len 3, from 0x100** → bank_addr 0x40..0x43 on consecutive cycles. INCR read of the same range returns the 4 words in order, r_last only on beat 4.
- **WRAP read, len 3, size 2, addr 0x18** → bank_addr sequence 6, 7, 4, 5.
- **Byte strobe write**: 0x000000AA with strb 0x1 over 0x11223344 → read returns 0x112233AA.
- **Simultaneous AW and AR valid after reset** → write accepted first. On the next conflict the read is accepted first.
- **Backpressure**: hold r_ready 0 for 5 cycles mid-burst → r_data stable, no extra bank_cs. Hold b_ready 0 → b_valid held, aw_ready stays 0.

Source files
------------

// File: rtl/axi_sram_ctrl_if.sv
// axi_sram_ctrl_if: AXI4 read/write channel bundle between interconnect master and SRAM controller slave
interface axi_sram_ctrl_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 5
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_valid, aw_ready;
   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last, w_valid, w_ready;
   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic                        b_valid, b_ready;
   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_valid, ar_ready;
   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last, r_valid, r_ready;
   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
      input  w_data, w_strb, w_last, w_valid, output w_ready,
      output b_id, b_resp, b_valid, input b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid, input r_ready
   );
   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
      output w_data, w_strb, w_last, w_valid, input w_ready,
      input  b_id, b_resp, b_valid, output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
      input  r_id, r_data, r_resp, r_last, r_valid, output r_ready
   );
endinterface

// File: rtl/axi_sram_ctrl.sv
// axi_sram_ctrl: AXI4 slave serving one burst at a time from a single synchronous SRAM bank
module axi_sram_ctrl #(
   parameter int AXI_ADDR_WIDTH       = 32,
   parameter int AXI_DATA_WIDTH       = 32,
   parameter int AXI_ID_WIDTH         = 5,
   parameter int SRAM_BANK_ADDR_WIDTH = 32,
   parameter int SRAM_BANK_DATA_WIDTH = 32,
   parameter int SRAM_READ_LATENCY    = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   axi_sram_ctrl_if.slave                  axi,
   output logic [SRAM_BANK_ADDR_WIDTH-1:0] bank_addr_o,
   output logic                            bank_cs_o,
   output logic                            bank_we_o,
   output logic [AXI_DATA_WIDTH/8-1:0]     bank_be_o,
   output logic [AXI_DATA_WIDTH-1:0]       bank_wdata_o,
   input  logic [SRAM_BANK_DATA_WIDTH-1:0] bank_rdata_i
);
   localparam int OFF = $clog2(AXI_DATA_WIDTH/8);
   localparam logic [AXI_ADDR_WIDTH-1:0] ONE = AXI_ADDR_WIDTH'(1);
   typedef enum logic [2:0] {IDLE, WRITE, WRESP, RISSUE, RWAIT, RDATA} state_t;
   state_t state_q, state_d;
   logic [AXI_ID_WIDTH-1:0] id_q, id_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt, size_b, incr, wrap_m;
   logic [7:0] len_q, len_d, beat_q, beat_d, lat_q, lat_d;
   logic [2:0] size_q, size_d;
   logic [1:0] burst_q, burst_d;
   logic last_wr_q, last_wr_d, pick_w, fire_w;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   // wrap window is (len+1)<<size bytes; AXI restricts len to 1,3,7,15 for WRAP
   always_comb begin
      size_b = ONE << size_q;
      incr = (addr_q & ~(size_b - ONE)) + size_b;
      wrap_m = ((AXI_ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
      addr_nxt = burst_q == 2'b00 ? addr_q : burst_q == 2'b10 ? (addr_q & ~wrap_m) | (incr & wrap_m) : incr;
   end
   assign pick_w = axi.aw_valid && !(axi.ar_valid && last_wr_q);
   assign fire_w = state_q == WRITE && axi.w_valid;
   assign axi.aw_ready = state_q == IDLE && pick_w;
   assign axi.ar_ready = state_q == IDLE && !pick_w && axi.ar_valid;
   assign axi.w_ready = state_q == WRITE;
   assign axi.b_valid = state_q == WRESP;
   assign axi.b_id = id_q;
   assign axi.b_resp = 2'b00;
   assign axi.r_valid = state_q == RDATA;
   assign axi.r_id = id_q;
   assign axi.r_data = rdata_q;
   assign axi.r_resp = 2'b00;
   assign axi.r_last = state_q == RDATA && beat_q == len_q;
   assign bank_cs_o = fire_w || state_q == RISSUE;
   assign bank_we_o = fire_w;
   assign bank_be_o = fire_w ? axi.w_strb : state_q == RISSUE ? '1 : '0;
   assign bank_wdata_o = fire_w ? axi.w_data : '0;
   assign bank_addr_o = SRAM_BANK_ADDR_WIDTH'(addr_q >> OFF);
   always_comb begin
      state_d = state_q;
      id_d = id_q;
      addr_d = addr_q;
      len_d = len_q;
      size_d = size_q;
      burst_d = burst_q;
      beat_d = beat_q;
      lat_d = lat_q;
      last_wr_d = last_wr_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (axi.aw_ready || axi.ar_ready) begin
            state_d = pick_w ? WRITE : RISSUE;
            id_d = pick_w ? axi.aw_id : axi.ar_id;
            addr_d = pick_w ? axi.aw_addr : axi.ar_addr;
            len_d = pick_w ? axi.aw_len : axi.ar_len;
            size_d = pick_w ? axi.aw_size : axi.ar_size;
            burst_d = pick_w ? axi.aw_burst : axi.ar_burst;
            beat_d = '0;
            last_wr_d = pick_w;
         end
         WRITE: if (axi.w_valid) begin
            addr_d = addr_nxt;
            beat_d = beat_q + 8'd1;
            if (axi.w_last || beat_q == len_q) state_d = WRESP;
         end
         WRESP: if (axi.b_ready) state_d = IDLE;
         RISSUE: begin
            state_d = RWAIT;
            lat_d = '0;
         end
         RWAIT: if (lat_q == 8'(SRAM_READ_LATENCY - 1)) begin
            rdata_d = bank_rdata_i;
            state_d = RDATA;
         end else lat_d = lat_q + 8'd1;
         RDATA: if (axi.r_ready) begin
            state_d = axi.r_last ? IDLE : RISSUE;
            addr_d = axi.r_last ? addr_q : addr_nxt;
            beat_d = axi.r_last ? beat_q : beat_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         id_q <= '0;
         addr_q <= '0;
         len_q <= '0;
         size_q <= '0;
         burst_q <= '0;
         beat_q <= '0;
         lat_q <= '0;
         last_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         id_q <= id_d;
         addr_q <= addr_d;
         len_q <= len_d;
         size_q <= size_d;
         burst_q <= burst_d;
         beat_q <= beat_d;
         lat_q <= lat_d;
         last_wr_q <= last_wr_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_axi_sram_ctrl.sv
// tb_axi_sram_ctrl: directed bench for axi_sram_ctrl against a 2-cycle-latency SRAM model
module tb_axi_sram_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   axi_sram_ctrl_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(5)) axi ();
   logic [31:0] bank_addr, bank_wdata, bank_rdata;
   logic bank_cs, bank_we;
   logic [3:0] bank_be;
   axi_sram_ctrl dut (
      .clk_i(clk), .rst_i(rst), .axi(axi),
      .bank_addr_o(bank_addr), .bank_cs_o(bank_cs), .bank_we_o(bank_we),
      .bank_be_o(bank_be), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
   );
   logic [31:0] mem [0:255];
   logic [31:0] pipe [0:1];
   int cyc = 0;
   logic [31:0] log_addr[$];
   logic log_we[$];
   logic [3:0] log_be[$];
   int log_cyc[$];
   assign bank_rdata = pipe[1];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      pipe[0] = '0;
      pipe[1] = '0;
   end
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bank_cs) begin
         log_addr.push_back(bank_addr);
         log_we.push_back(bank_we);
         log_be.push_back(bank_be);
         log_cyc.push_back(cyc);
      end
      if (bank_cs && bank_we)
         for (int b = 0; b < 4; b++) if (bank_be[b]) mem[bank_addr[7:0]][b*8 +: 8] <= bank_wdata[b*8 +: 8];
      pipe[0] <= (bank_cs && !bank_we) ? mem[bank_addr[7:0]] : 32'h0;
      pipe[1] <= pipe[0];
   end
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] wq[$], rq[$];
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_be.delete();
      log_cyc.delete();
   endtask
   task automatic wait_rvalid();
      int n = 0;
      while (!axi.r_valid && n < 20) begin
         tick();
         n++;
      end
      check("r_latency", n, 3);
   endtask
   task automatic axi_write(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb);
      int n = 0;
      axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len; axi.aw_size = 3'd2; axi.aw_burst = burst;
      axi.aw_valid = 1'b1;
      #1;
      while (!axi.aw_ready && n < 20) begin
         tick();
         n++;
      end
      check("aw_ready", axi.aw_ready, 1);
      tick();
      axi.aw_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         axi.w_data = wq[i]; axi.w_strb = strb; axi.w_last = (i == int'(len)); axi.w_valid = 1'b1;
         #1;
         check("w_ready", axi.w_ready, 1);
         tick();
      end
      axi.w_valid = 1'b0;
      axi.w_last = 1'b0;
      #1;
      check("b_valid", axi.b_valid, 1);
      check("b_id", axi.b_id, id);
      check("b_resp", axi.b_resp, 0);
      axi.b_ready = 1'b1;
      tick();
      axi.b_ready = 1'b0;
   endtask
   task automatic axi_read(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int hold_beat);
      int n = 0;
      int c;
      axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len; axi.ar_size = 3'd2; axi.ar_burst = burst;
      axi.ar_valid = 1'b1;
      #1;
      while (!axi.ar_ready && n < 20) begin
         tick();
         n++;
      end
      check("ar_ready", axi.ar_ready, 1);
      tick();
      axi.ar_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wait_rvalid();
         check("r_data", axi.r_data, rq[i]);
         check("r_last", axi.r_last, i == int'(len));
         check("r_id", axi.r_id, id);
         check("r_resp", axi.r_resp, 0);
         if (i == hold_beat) begin
            c = log_addr.size();
            for (int k = 0; k < 5; k++) begin
               tick();
               check("hold_r_valid", axi.r_valid, 1);
               check("hold_r_data", axi.r_data, rq[i]);
            end
            check("hold_no_cs", log_addr.size(), c);
         end
         axi.r_ready = 1'b1;
         tick();
         axi.r_ready = 1'b0;
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0; axi.aw_burst = '0; axi.aw_valid = 1'b0;
      axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0; axi.w_valid = 1'b0; axi.b_ready = 1'b0;
      axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0; axi.ar_burst = '0; axi.ar_valid = 1'b0;
      axi.r_ready = 1'b0;
      repeat (2) tick();
      check("reset_ctl", {axi.aw_ready, axi.w_ready, axi.b_valid, axi.ar_ready, axi.r_valid, axi.r_last, bank_cs, bank_we}, 0);
      check("reset_bank", {bank_be, bank_addr}, 0);
      check("reset_data", {bank_wdata, axi.r_data}, 0);
      check("reset_bresp", axi.b_resp, 0);
      rst = 1'b0;
      tick();
      // single write then read
      clear_log();
      wq = '{32'hDEADBEEF};
      axi_write(5'd3, 32'h10, 8'd0, 2'b01, 4'hF);
      check("sw_cs_count", log_addr.size(), 1);
      check("sw_addr", log_addr[0], 32'h4);
      check("sw_we", log_we[0], 1);
      check("sw_be", log_be[0], 4'hF);
      rq = '{32'hDEADBEEF};
      axi_read(5'd3, 32'h10, 8'd0, 2'b01, -1);
      // INCR burst write/read with mid-burst read backpressure
      clear_log();
      wq = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
      axi_write(5'd5, 32'h100, 8'd3, 2'b01, 4'hF);
      for (int i = 0; i < 4; i++) begin
         check("incr_w_addr", log_addr[i], 32'h40 + 32'(i));
         check("incr_w_cycle", log_cyc[i] - log_cyc[0], i);
      end
      clear_log();
      rq = wq;
      axi_read(5'd6, 32'h100, 8'd3, 2'b01, 1);
      check("incr_r_cs_count", log_addr.size(), 4);
      for (int i = 0; i < 4; i++) check("incr_r_cs", {log_we[i], log_be[i], log_addr[i]}, {1'b0, 4'hF, 32'h40 + 32'(i)});
      // WRAP read
      wq = '{32'h10, 32'h11, 32'h12, 32'h13};
      axi_write(5'd1, 32'h10, 8'd3, 2'b01, 4'hF);
      clear_log();
      rq = '{32'h12, 32'h13, 32'h10, 32'h11};
      axi_read(5'd9, 32'h18, 8'd3, 2'b10, -1);
      check("wrap_cs_count", log_addr.size(), 4);
      check("wrap_a0", log_addr[0], 6);
      check("wrap_a1", log_addr[1], 7);
      check("wrap_a2", log_addr[2], 4);
      check("wrap_a3", log_addr[3], 5);
      // byte strobe
      wq = '{32'h11223344};
      axi_write(5'd2, 32'h20, 8'd0, 2'b01, 4'hF);
      wq = '{32'h000000AA};
      axi_write(5'd2, 32'h20, 8'd0, 2'b01, 4'h1);
      rq = '{32'h112233AA};
      axi_read(5'd2, 32'h20, 8'd0, 2'b01, -1);
      // reset mid-burst: no response
      axi.aw_id = 5'd1; axi.aw_addr = 32'h80; axi.aw_len = 8'd3; axi.aw_size = 3'd2; axi.aw_burst = 2'b01;
      axi.aw_valid = 1'b1;
      #1;
      check("mid_aw_ready", axi.aw_ready, 1);
      tick();
      axi.aw_valid = 1'b0;
      axi.w_data = 32'h77; axi.w_strb = 4'hF; axi.w_last = 1'b0; axi.w_valid = 1'b1;
      tick();
      axi.w_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_rst", {axi.b_valid, axi.w_ready, bank_cs}, 0);
      rst = 1'b0;
      repeat (3) tick();
      check("mid_no_b", axi.b_valid, 0);
      // arbitration after reset, plus b backpressure
      axi.ar_id = 5'd7; axi.ar_addr = 32'h20; axi.ar_len = 8'd0; axi.ar_size = 3'd2; axi.ar_burst = 2'b01;
      axi.ar_valid = 1'b1;
      axi.aw_id = 5'd2; axi.aw_addr = 32'h44; axi.aw_len = 8'd0; axi.aw_size = 3'd2; axi.aw_burst = 2'b01;
      axi.aw_valid = 1'b1;
      #1;
      check("arb1_aw", axi.aw_ready, 1);
      check("arb1_ar", axi.ar_ready, 0);
      tick();
      axi.aw_id = 5'd4; axi.aw_addr = 32'h48;
      axi.w_data = 32'h66; axi.w_strb = 4'hF; axi.w_last = 1'b1; axi.w_valid = 1'b1;
      #1;
      check("wr_aw_ready", axi.aw_ready, 0);
      tick();
      axi.w_valid = 1'b0;
      axi.w_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bhold_valid", axi.b_valid, 1);
         check("bhold_aw_ready", axi.aw_ready, 0);
         tick();
      end
      axi.b_ready = 1'b1;
      #1;
      check("arb_b_id", axi.b_id, 2);
      tick();
      axi.b_ready = 1'b0;
      #1;
      check("arb2_ar", axi.ar_ready, 1);
      check("arb2_aw", axi.aw_ready, 0);
      tick();
      axi.ar_valid = 1'b0;
      wait_rvalid();
      check("arb_r_data", axi.r_data, 32'h112233AA);
      check("arb_r_id", axi.r_id, 7);
      axi.r_ready = 1'b1;
      tick();
      axi.r_ready = 1'b0;
      #1;
      check("arb3_aw", axi.aw_ready, 1);
      tick();
      axi.aw_valid = 1'b0;
      axi.w_data = 32'h99; axi.w_last = 1'b1; axi.w_valid = 1'b1;
      tick();
      axi.w_valid = 1'b0;
      axi.w_last = 1'b0;
      #1;
      check("arb3_b_valid", axi.b_valid, 1);
      check("arb3_b_id", axi.b_id, 4);
      axi.b_ready = 1'b1;
      tick();
      axi.b_ready = 1'b0;
      rq = '{32'h66};
      axi_read(5'd1, 32'h44, 8'd0, 2'b01, -1);
      rq = '{32'h99};
      axi_read(5'd1, 32'h48, 8'd0, 2'b01, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
